// File: rtl/axis_video_out.sv
// sync_fifo: single-clock circular buffer; clr_i drops all entries but keeps a same-cycle push.
// Latency: a pushed entry is visible on pop_dat_o the cycle after it is written.
// Backpressure: writes are ignored when full (unless clearing); reads are ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_en     = push_i && (!full_o || clr_i);
  assign rd_en     = pop_i && !empty_o && !clr_i;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    // Flush by catching the read pointer up to the write pointer.
    if (clr_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CW'(wr_en);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

// axis_video_out: locks an AXI-Stream pixel feed to a parameterised raster and drives 24-bit RGB.
// Latency: vid_* and syncs are registered one cycle after the raster position that produced them.
// Backpressure: tready drops when the FIFO is full; while unlocked every beat is accepted.
module axis_video_out #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [23:0] BLANK_RGB  = 24'h000000
) (
  input  logic        s_axis_vid_aclk,
  input  logic        s_axis_vid_aresetn,
  input  logic [31:0] s_axis_vid_tdata,
  input  logic        s_axis_vid_tlast,
  input  logic        s_axis_vid_tuser,
  input  logic        s_axis_vid_tvalid,
  output logic        s_axis_vid_tready,
  output logic [23:0] vid_data,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic        locked,
  output logic        err_underflow,
  output logic        err_framing,
  input  logic        err_clr
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ARMED,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] rgb;
  } entry_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [23:0]   data_q, data_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          uf_q, uf_d;
  logic          fr_q, fr_d;

  logic          active;
  logic          origin;
  logic          line_end;
  logic          hs_on;
  logic          vs_on;
  logic          beat_acc;
  logic          push;
  logic          pop;
  logic          serve;
  logic          set_uf;
  logic          set_fr;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        push_ent;
  entry_t        head;
  logic          unused_x;

  assign unused_x = ^s_axis_vid_tdata[7:0];

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (int'(h_q) == H_TOTAL - 1) begin
      h_d = '0;
      v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
    end
  end

  assign active   = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign origin   = (h_q == '0) && (v_q == '0);
  assign line_end = (int'(h_q) == H_ACTIVE - 1);
  assign hs_on    = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on    = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);

  // While unlocked the FIFO is held empty, so a lone SOF beat always lands at the head.
  assign s_axis_vid_tready = (state_q == ST_UNLOCKED) || !fifo_full;
  assign beat_acc          = s_axis_vid_tvalid && s_axis_vid_tready;
  assign push              = beat_acc && ((state_q != ST_UNLOCKED) || s_axis_vid_tuser);
  assign push_ent          = '{user: s_axis_vid_tuser, last: s_axis_vid_tlast,
                               rgb: s_axis_vid_tdata[31:8]};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (s_axis_vid_aclk),
    .rst_ni     (s_axis_vid_aresetn),
    .clr_i      (state_q == ST_UNLOCKED),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    serve   = 1'b0;
    pop     = 1'b0;
    set_uf  = 1'b0;
    set_fr  = 1'b0;
    case (state_q)
      ST_UNLOCKED: if (beat_acc && s_axis_vid_tuser) state_d = ST_ARMED;
      ST_ARMED: begin
        if (origin) begin
          state_d = ST_LOCKED;
          serve   = 1'b1;
        end
      end
      ST_LOCKED: serve = active;
      default:   state_d = ST_UNLOCKED;
    endcase
    // Every active pixel consumes one entry; a missing or misplaced one drops lock.
    if (serve) begin
      if (fifo_empty) begin
        set_uf  = 1'b1;
        state_d = ST_UNLOCKED;
      end else begin
        pop = 1'b1;
        if ((head.user != origin) || (head.last != line_end)) begin
          set_fr  = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end
    end
  end

  always_comb begin
    de_d    = active;
    hsync_d = hs_on ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = vs_on ? VSYNC_POL : ~VSYNC_POL;
    data_d  = '0;
    if (active) data_d = pop ? head.rgb : BLANK_RGB;
    uf_d    = set_uf || (uf_q && !err_clr);
    fr_d    = set_fr || (fr_q && !err_clr);
  end

  always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
    if (!s_axis_vid_aresetn) begin
      state_q <= ST_UNLOCKED;
      h_q     <= '0;
      v_q     <= '0;
      data_q  <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      uf_q    <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      data_q  <= data_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      uf_q    <= uf_d;
      fr_q    <= fr_d;
    end
  end

  assign vid_data      = data_q;
  assign vid_de        = de_q;
  assign vid_hsync     = hsync_q;
  assign vid_vsync     = vsync_q;
  assign locked        = (state_q == ST_LOCKED);
  assign err_underflow = uf_q;
  assign err_framing   = fr_q;
endmodule

// File: tb/tb_axis_video_out.sv
// Random-stimulus bench for axis_video_out on a 14x7 raster, checked cycle by cycle
// against a queue-based model of the lock / pop / error rules.
module tb_axis_video_out;
  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HTOT = HA + HFP + HS + HBP;
  localparam int VTOT = VA + VFP + VS + VBP;
  localparam int FRAME = HTOT * VTOT;
  localparam int DEPTH = 16;
  localparam logic [23:0] BLANK = 24'h5A3C69;
  localparam int UNL = 0, ARM = 1, LCK = 2;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] rgb;
    logic [7:0]  x;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [23:0] vid_data;
  logic        vid_hsync, vid_vsync, vid_de, locked;
  logic        err_underflow, err_framing;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  axis_video_out #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
    .FIFO_DEPTH (DEPTH), .BLANK_RGB (BLANK)
  ) dut (
    .s_axis_vid_aclk    (clk),
    .s_axis_vid_aresetn (aresetn),
    .s_axis_vid_tdata   (tdata),
    .s_axis_vid_tlast   (tlast),
    .s_axis_vid_tuser   (tuser),
    .s_axis_vid_tvalid  (tvalid),
    .s_axis_vid_tready  (tready),
    .vid_data           (vid_data),
    .vid_hsync          (vid_hsync),
    .vid_vsync          (vid_vsync),
    .vid_de             (vid_de),
    .locked             (locked),
    .err_underflow      (err_underflow),
    .err_framing        (err_framing),
    .err_clr            (err_clr)
  );

  int    n_chk = 0;
  int    n_pass = 0;
  string phase = "init";

  beat_t src_q[$];
  beat_t cur = '0;
  bit    vld_hold = 1'b0;
  int    stall = 0;
  int    rate = 0;
  bit    clr_req = 1'b0;
  bit    rand_clr = 1'b0;

  int          m_h, m_v, m_mode;
  logic [25:0] m_q[$];
  bit          m_eu, m_ef;
  logic [5:0]  exp_ctl;
  logic [23:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL [%s] %s: got %0h, expected %0h at %0t", phase, tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = UNL;
    m_q.delete();
    m_eu = 1'b0; m_ef = 1'b0;
    exp_ctl = 6'b011000;
    exp_data = '0;
  endtask

  // One raster pixel: what the next clock edge must produce.
  task automatic model_step(input bit acc, input logic [25:0] ent, input bit clr);
    bit act, org, set_u, set_f;
    int nm;
    logic [25:0] e;
    act = (m_h < HA) && (m_v < VA);
    org = (m_h == 0) && (m_v == 0);
    set_u = 1'b0; set_f = 1'b0;
    nm = m_mode;
    exp_data = act ? BLANK : 24'h0;
    if (m_mode == ARM && org) nm = LCK;
    if (nm == LCK && act) begin
      if (m_q.size() == 0) begin
        set_u = 1'b1; nm = UNL;
      end else begin
        e = m_q.pop_front();
        exp_data = e[23:0];
        if (e[25] != org || e[24] != (m_h == HA - 1)) begin
          set_f = 1'b1; nm = UNL;
        end
      end
    end
    if (m_mode == UNL) begin
      m_q.delete();
      if (acc && ent[25]) begin
        m_q.push_back(ent);
        nm = ARM;
      end
    end else if (acc) begin
      m_q.push_back(ent);
    end
    m_eu = (m_eu && !clr) || set_u;
    m_ef = (m_ef && !clr) || set_f;
    exp_ctl = {act,
               !(m_h >= HA + HFP && m_h < HA + HFP + HS),
               !(m_v >= VA + VFP && m_v < VA + VFP + VS),
               nm == LCK, m_eu, m_ef};
    m_mode = nm;
    m_h = m_h + 1;
    if (m_h == HTOT) begin
      m_h = 0;
      m_v = (m_v + 1) % VTOT;
    end
  endtask

  task automatic drive_and_step();
    bit rdy_exp, acc;
    beat_t b;
    if (!vld_hold) begin
      if (stall > 0 || src_q.size() == 0 || $urandom_range(99) >= rate) tvalid = 1'b0;
      else begin
        tvalid = 1'b1;
        cur = src_q[0];
      end
    end
    if (stall > 0) stall--;
    tdata = {cur.rgb, cur.x};
    tuser = cur.user;
    tlast = cur.last;
    err_clr = clr_req || (rand_clr && $urandom_range(15) == 0);
    #1;
    rdy_exp = (m_mode == UNL) || (m_q.size() < DEPTH);
    chk("tready", 32'(tready), 32'(rdy_exp));
    acc = tvalid && rdy_exp;
    if (acc) b = src_q.pop_front();
    vld_hold = tvalid && !rdy_exp;
    model_step(acc, {cur.user, cur.last, cur.rgb}, err_clr);
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("ctl", 32'({vid_de, vid_hsync, vid_vsync, locked, err_underflow, err_framing}),
        32'(exp_ctl));
    if (exp_ctl[5]) chk("pix", 32'(vid_data), 32'(exp_data));
    drive_and_step();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int hold);
    aresetn = 1'b0;
    tvalid = 1'b0;
    err_clr = 1'b0;
    vld_hold = 1'b0;
    stall = 0;
    clr_req = 1'b0;
    #1;
    chk("rst_ctl", 32'({vid_de, vid_hsync, vid_vsync, locked, err_underflow, err_framing}),
        32'(6'b011000));
    chk("rst_data", 32'(vid_data), 32'(0));
    chk("rst_rdy", 32'(tready), 32'(1));
    repeat (hold) @(negedge clk);
    aresetn = 1'b1;
    model_reset();
    drive_and_step();
  endtask

  task automatic add_beat(input bit user, input bit last);
    beat_t b;
    logic [31:0] r;
    r = $urandom;
    b.rgb = r[31:8];
    b.x = r[7:0];
    b.user = user;
    b.last = last;
    src_q.push_back(b);
  endtask

  task automatic add_frame(input int bad_l, input int bad_p);
    for (int l = 0; l < VA; l++)
      for (int p = 0; p < HA; p++)
        add_beat(l == 0 && p == 0, (p == HA - 1) || (l == bad_l && p == bad_p));
  endtask

  initial begin
    int n, seen;
    model_reset();
    #3;
    phase = "reset";
    do_reset(2);

    phase = "timing";
    rate = 0;
    run(2 * FRAME);

    phase = "frames";
    src_q.delete();
    do_reset(2);
    rate = 100;
    repeat (5) add_frame(-1, -1);
    seen = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      cycle();
      if (locked) seen++;
    end
    chk("lock_cycles", 32'(seen >= 2 * FRAME), 32'(1));

    phase = "garbage";
    src_q.delete();
    do_reset(2);
    rate = 85;
    repeat (5) add_beat(1'b0, 1'b0);
    repeat (3) add_frame(-1, -1);
    run(3 * FRAME + 20);

    phase = "underflow";
    src_q.delete();
    do_reset(2);
    rate = 100;
    repeat (4) add_frame(-1, -1);
    n = 0;
    while (!(m_mode == LCK && m_v == 1 && m_h == 4) && n < 3 * FRAME) begin cycle(); n++; end
    chk("uf_reach_line1", 32'(n < 3 * FRAME), 32'(1));
    stall = 40;
    n = 0;
    while (!m_eu && n < FRAME) begin cycle(); n++; end
    cycle();
    chk("uf_flag", 32'({err_underflow, locked}), 32'(2'b10));
    n = 0;
    while (m_mode != LCK && n < 3 * FRAME) begin cycle(); n++; end
    chk("uf_relock", 32'(n < 3 * FRAME), 32'(1));
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    run(FRAME);

    phase = "framing";
    src_q.delete();
    do_reset(2);
    rate = 100;
    add_frame(-1, -1);
    add_frame(1, 6);
    repeat (3) add_frame(-1, -1);
    seen = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      cycle();
      if (err_framing) seen++;
    end
    chk("fr_seen", 32'(seen > 0), 32'(1));

    phase = "backpressure";
    src_q.delete();
    do_reset(2);
    rate = 70;
    rand_clr = 1'b1;
    repeat (5) add_frame(-1, -1);
    run(150);
    n = 0;
    while (!(m_h == 3 && m_v == 1) && n < 2 * FRAME) begin cycle(); n++; end
    chk("mid_line_reach", 32'(n < 2 * FRAME), 32'(1));
    phase = "midreset";
    do_reset(2);
    run(3 * FRAME);
    rand_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
